// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: widths, FSM
// encoding and requester indices.
package regfile_write_arbiter_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;
   localparam int NREGS  = 16;

   // FSM state names the source currently driven onto the write port
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WR0  = 2'd1;
   localparam logic [1:0] ST_WR1  = 2'd2;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_MEM = 1'b1;

   function automatic logic other_req(input logic idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the two writeback requesters, the register-file write port
// and decode. Bypass read ports exist only with REGFILE_ARB_BYPASS_EN.
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = regfile_write_arbiter_pkg::ADDR_W,
   parameter int DATA_W = regfile_write_arbiter_pkg::DATA_W,
   parameter int NREGS  = regfile_write_arbiter_pkg::NREGS
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;

   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;

   logic [ADDR_W-1:0] rf_c;
   logic [DATA_W-1:0] rf_pc;
   logic              rf_enable;
   logic [NREGS-1:0]  pending_mask;
   logic              busy;

`ifdef REGFILE_ARB_BYPASS_EN
   logic [ADDR_W-1:0] rd_a;
   logic [ADDR_W-1:0] rd_b;
   logic              fwd_a_hit;
   logic              fwd_b_hit;
   logic [DATA_W-1:0] fwd_a_data;
   logic [DATA_W-1:0] fwd_b_data;
`endif

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      input  rf_c, rf_pc, rf_enable, pending_mask, busy
`ifdef REGFILE_ARB_BYPASS_EN
      , output rd_a, rd_b,
      input  fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data
`endif
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      output rf_c, rf_pc, rf_enable, pending_mask, busy
`ifdef REGFILE_ARB_BYPASS_EN
      , input rd_a, rd_b,
      output fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data
`endif
   );

endinterface

// File: rtl/regfile_hold_slot.sv
// One-entry holding register for a writeback requester. Ready is purely the
// empty flag; the entry frees on the edge it is granted.
module regfile_hold_slot #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_grant,
   output logic              o_ready,
   output logic              o_load,
   output logic              o_held,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   assign o_ready = ~r_valid;
   assign o_load  = i_valid & ~r_valid;
   assign o_held  = r_valid;
   assign o_addr  = r_addr;
   assign o_data  = r_data;

   // A held entry cannot be reloaded and granted on the same edge since ready is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (o_load) begin
         r_valid <= 1'b1;
         r_addr  <= i_addr;
         r_data  <= i_data;
      end else if (i_grant) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two writeback requesters onto the single register-file write port,
// round-robin with oldest-first on same-address conflicts. Optional bypass
// forwarding is enabled by defining REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
   parameter int DATA_W = regfile_write_arbiter_pkg::DATA_W,
   parameter int ADDR_W = regfile_write_arbiter_pkg::ADDR_W,
   parameter int NREGS  = regfile_write_arbiter_pkg::NREGS
) (
   input logic                   CLK,
   input logic                   RESET,
   regfile_write_arbiter_if.slave bus
);
   import regfile_write_arbiter_pkg::*;

   localparam logic [NREGS-1:0] ONE_HOT_LSB = {{(NREGS-1){1'b0}}, 1'b1};

   logic [1:0]        w_req_valid;
   logic [ADDR_W-1:0] w_req_addr  [2];
   logic [DATA_W-1:0] w_req_data  [2];
   logic [1:0]        w_ready;
   logic [1:0]        w_load;
   logic [1:0]        w_held;
   logic [1:0]        w_grant;
   logic [ADDR_W-1:0] w_hold_addr [2];
   logic [DATA_W-1:0] w_hold_data [2];

   logic              w_gnt_vld;
   logic              w_gnt_idx;
   logic              w_rr_update;
   logic              w_age_next;
   logic [NREGS-1:0]  w_pending;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_rf_c;
   logic [DATA_W-1:0] r_rf_pc;
   logic              r_rr_ptr;
   logic              r_age;

   assign w_req_valid[0] = bus.req0_valid;
   assign w_req_addr[0]  = bus.req0_addr;
   assign w_req_data[0]  = bus.req0_data;
   assign w_req_valid[1] = bus.req1_valid;
   assign w_req_addr[1]  = bus.req1_addr;
   assign w_req_data[1]  = bus.req1_data;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         regfile_hold_slot #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
         ) u_slot (
            .clk     (CLK),
            .rst_n   (RESET),
            .i_valid (w_req_valid[gi]),
            .i_addr  (w_req_addr[gi]),
            .i_data  (w_req_data[gi]),
            .i_grant (w_grant[gi]),
            .o_ready (w_ready[gi]),
            .o_load  (w_load[gi]),
            .o_held  (w_held[gi]),
            .o_addr  (w_hold_addr[gi]),
            .o_data  (w_hold_data[gi])
         );
      end
   endgenerate

   // r_age names the older slot; rr_ptr only moves on a different-address contest
   always_comb begin
      w_gnt_vld   = 1'b0;
      w_gnt_idx   = REQ_ALU;
      w_rr_update = 1'b0;
      case (w_held)
         2'b01: begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = REQ_ALU;
         end
         2'b10: begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = REQ_MEM;
         end
         2'b11: begin
            w_gnt_vld = 1'b1;
            if (w_hold_addr[0] == w_hold_addr[1]) begin
               w_gnt_idx = r_age;
            end else begin
               w_gnt_idx   = other_req(r_rr_ptr);
               w_rr_update = 1'b1;
            end
         end
         default: begin
            w_gnt_vld = 1'b0;
         end
      endcase
   end

   assign w_grant[0] = w_gnt_vld & (w_gnt_idx == REQ_ALU);
   assign w_grant[1] = w_gnt_vld & (w_gnt_idx == REQ_MEM);

   // A newly loaded entry is younger only if the other slot stays occupied past this edge
   always_comb begin
      w_age_next = r_age;
      case (w_load)
         2'b11:   w_age_next = REQ_ALU;
         2'b01:   w_age_next = (w_held[1] & ~w_grant[1]) ? REQ_MEM : REQ_ALU;
         2'b10:   w_age_next = (w_held[0] & ~w_grant[0]) ? REQ_ALU : REQ_MEM;
         default: w_age_next = r_age;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state  <= ST_IDLE;
         r_rf_c   <= '0;
         r_rf_pc  <= '0;
         r_rr_ptr <= REQ_ALU;
         r_age    <= REQ_ALU;
      end else begin
         r_age <= w_age_next;
         if (w_rr_update) begin
            r_rr_ptr <= w_gnt_idx;
         end
         if (w_gnt_vld) begin
            r_state <= (w_gnt_idx == REQ_MEM) ? ST_WR1 : ST_WR0;
            r_rf_c  <= w_hold_addr[w_gnt_idx];
            r_rf_pc <= w_hold_data[w_gnt_idx];
         end else begin
            r_state <= ST_IDLE;
         end
      end
   end

   always_comb begin
      w_pending = '0;
      for (int i = 0; i < 2; i++) begin
         if (w_held[i]) begin
            w_pending = w_pending | (ONE_HOT_LSB << w_hold_addr[i]);
         end
      end
      if (r_state != ST_IDLE) begin
         w_pending = w_pending | (ONE_HOT_LSB << r_rf_c);
      end
   end

   assign bus.req0_ready   = w_ready[0];
   assign bus.req1_ready   = w_ready[1];
   assign bus.rf_c         = r_rf_c;
   assign bus.rf_pc        = r_rf_pc;
   assign bus.rf_enable    = (r_state != ST_IDLE);
   assign bus.pending_mask = w_pending;
   assign bus.busy         = (|w_held) | (r_state != ST_IDLE);

`ifdef REGFILE_ARB_BYPASS_EN
   logic              w_young_idx;
   logic              w_old_idx;
   logic [ADDR_W-1:0] w_rd    [2];
   logic [1:0]        w_hit;
   logic [DATA_W-1:0] w_fwd   [2];

   assign w_young_idx = other_req(r_age);
   assign w_old_idx   = r_age;
   assign w_rd[0]     = bus.rd_a;
   assign w_rd[1]     = bus.rd_b;

   // Youngest pending copy wins: younger hold, older hold, then the port entry
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         logic w_young_hit;
         logic w_old_hit;
         logic w_port_hit;

         assign w_young_hit = w_held[w_young_idx] & (w_hold_addr[w_young_idx] == w_rd[gi]);
         assign w_old_hit   = w_held[w_old_idx] & (w_hold_addr[w_old_idx] == w_rd[gi]);
         assign w_port_hit  = (r_state != ST_IDLE) & (r_rf_c == w_rd[gi]);
         assign w_hit[gi]   = w_young_hit | w_old_hit | w_port_hit;
         assign w_fwd[gi]   = w_young_hit ? w_hold_data[w_young_idx] :
                              w_old_hit   ? w_hold_data[w_old_idx]   : r_rf_pc;
      end
   endgenerate

   assign bus.fwd_a_hit  = w_hit[0];
   assign bus.fwd_b_hit  = w_hit[1];
   assign bus.fwd_a_data = w_fwd[0];
   assign bus.fwd_b_data = w_fwd[1];
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run against an arrival-order reference model.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   regfile_write_arbiter_if bus ();

   regfile_write_arbiter dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Register file fed by the write port, plus an ordered log of writes
   logic [31:0] tb_rf [16];
   logic [35:0] wlog [$];
   always @(posedge CLK) begin
      if (bus.rf_enable) begin
         tb_rf[bus.rf_c] <= bus.rf_pc;
         wlog.push_back({bus.rf_c, bus.rf_pc});
      end
   end

   // Reference model: entries stamped with arrival order
   logic        m_v   [2];
   logic [3:0]  m_a   [2];
   logic [31:0] m_d   [2];
   int          m_seq [2];
   int          m_ctr;
   logic        m_rr;
   logic        m_en;
   logic [3:0]  m_c;
   logic [31:0] m_pc;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_v[i] = 1'b0; m_a[i] = '0; m_d[i] = '0; m_seq[i] = 0;
      end
      m_ctr = 0; m_rr = 1'b0; m_en = 1'b0; m_c = '0; m_pc = '0;
   endtask

   task automatic model_step();
      logic r0, r1;
      int g;
      r0 = !m_v[0];
      r1 = !m_v[1];
      g  = -1;
      if (m_v[0] && m_v[1]) begin
         if (m_a[0] == m_a[1]) g = (m_seq[0] < m_seq[1]) ? 0 : 1;
         else begin
            g = m_rr ? 0 : 1;
            m_rr = (g == 1);
         end
      end else if (m_v[0]) g = 0;
      else if (m_v[1]) g = 1;
      if (g >= 0) begin
         m_en = 1'b1; m_c = m_a[g]; m_pc = m_d[g]; m_v[g] = 1'b0;
      end else begin
         m_en = 1'b0;
      end
      if (bus.req0_valid && r0) begin
         m_v[0] = 1'b1; m_a[0] = bus.req0_addr; m_d[0] = bus.req0_data; m_seq[0] = m_ctr; m_ctr++;
      end
      if (bus.req1_valid && r1) begin
         m_v[1] = 1'b1; m_a[1] = bus.req1_addr; m_d[1] = bus.req1_data; m_seq[1] = m_ctr; m_ctr++;
      end
   endtask

   function automatic logic [15:0] model_mask();
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 2; i++) if (m_v[i]) m[m_a[i]] = 1'b1;
      if (m_en) m[m_c] = 1'b1;
      return m;
   endfunction

`ifdef REGFILE_ARB_BYPASS_EN
   task automatic model_fwd(input logic [3:0] rd, output logic hit, output logic [31:0] d);
      int best;
      best = -1;
      for (int i = 0; i < 2; i++)
         if (m_v[i] && m_a[i] == rd && (best < 0 || m_seq[i] > m_seq[best])) best = i;
      hit = 1'b1;
      d   = '0;
      if (best >= 0) d = m_d[best];
      else if (m_en && m_c == rd) d = m_pc;
      else hit = 1'b0;
   endtask
`endif

   task automatic drive_idle();
      bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
      bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
`ifdef REGFILE_ARB_BYPASS_EN
      bus.rd_a = '0; bus.rd_b = '0;
`endif
   endtask

   // Model advances with the same inputs the DUT samples at the coming edge
   task automatic tick();
      model_step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      drive_idle();
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [57:0] got;
      drive_idle();
      RESET = 1'b0;
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      got = {bus.rf_enable, bus.rf_c, bus.rf_pc, bus.pending_mask, bus.busy, bus.req0_ready, bus.req1_ready, 2'b00};
      n_tests++;
      if (got !== {1'b0, 4'h0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'b00}) begin
         n_fail++; $display("FAIL reset_init: got %h expected %h", got, {1'b0, 4'h0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'b00});
      end
      RESET = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_addr = 4'd9;  bus.req0_data = 32'h1;
      bus.req1_valid = 1'b1; bus.req1_addr = 4'd10; bus.req1_data = 32'h2;
      tick();
      drive_idle();
      tick();
      n_tests++;
      if ({bus.rf_enable, bus.req0_ready} !== 2'b10) begin
         n_fail++; $display("FAIL reset_pre: got en/rdy0 %b expected 10", {bus.rf_enable, bus.req0_ready});
      end
      #2 RESET = 1'b0;
      #1;
      got = {bus.rf_enable, bus.rf_c, bus.rf_pc, bus.pending_mask, bus.busy, bus.req0_ready, bus.req1_ready, 2'b00};
      n_tests++;
      if (got !== {1'b0, 4'h0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'b00}) begin
         n_fail++; $display("FAIL reset_async: got %h expected %h", got, {1'b0, 4'h0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b1, 2'b00});
      end
      @(negedge CLK);
      RESET = 1'b1;
      model_reset();
      @(negedge CLK);
      n_tests++;
      if ({bus.req0_ready, bus.pending_mask} !== {1'b1, 16'h0}) begin
         n_fail++; $display("FAIL reset_release: got rdy0 %b mask %h expected 1 0000", bus.req0_ready, bus.pending_mask);
      end
      $display("[TB] reset done");
   endtask

   task automatic test_single_write();
      bus.req0_valid = 1'b1; bus.req0_addr = 4'd3; bus.req0_data = 32'hDEADBEEF;
      tick();
      drive_idle();
      n_tests++;
      if ({bus.rf_enable, bus.req0_ready, bus.busy, bus.pending_mask} !== {3'b001, 16'h0008}) begin
         n_fail++; $display("FAIL single_held: got en/rdy/busy %b mask %h expected 001 0008", {bus.rf_enable, bus.req0_ready, bus.busy}, bus.pending_mask);
      end
      tick();
      n_tests++;
      if ({bus.rf_enable, bus.rf_c, bus.rf_pc, bus.pending_mask} !== {1'b1, 4'd3, 32'hDEADBEEF, 16'h0008}) begin
         n_fail++; $display("FAIL single_port: got en %b c %0d pc %h mask %h expected 1 3 deadbeef 0008", bus.rf_enable, bus.rf_c, bus.rf_pc, bus.pending_mask);
      end
      tick();
      n_tests++;
      if ({bus.rf_enable, bus.busy, bus.pending_mask, tb_rf[3]} !== {2'b00, 16'h0, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL single_done: got en/busy %b mask %h rf3 %h expected 00 0000 deadbeef", {bus.rf_enable, bus.busy}, bus.pending_mask, tb_rf[3]);
      end
      $display("[TB] single write addr 3 data deadbeef");
   endtask

   task automatic test_round_robin();
      int cnt0, cnt1;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 20; i++) begin
         bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = $urandom;
         bus.req1_valid = 1'b1; bus.req1_addr = 4'd2; bus.req1_data = $urandom;
         tick();
         n_tests++;
         if ({bus.rf_enable, bus.rf_c, bus.rf_pc} !== {m_en, m_c, m_pc}) begin
            n_fail++; $display("FAIL rr_cycle %0d: got en %b c %0d pc %h expected %b %0d %h", i, bus.rf_enable, bus.rf_c, bus.rf_pc, m_en, m_c, m_pc);
         end
         if (bus.rf_enable && bus.rf_c == 4'd1) cnt0++;
         if (bus.rf_enable && bus.rf_c == 4'd2) cnt1++;
      end
      drive_idle();
      tick(); tick(); tick();
      n_tests++;
      if (cnt0 < 9 || cnt1 < 9) begin
         n_fail++; $display("FAIL rr_fair: got grants %0d/%0d expected each >= 9", cnt0, cnt1);
      end
      $display("[TB] round robin grants req0=%0d req1=%0d", cnt0, cnt1);
   endtask

   task automatic test_same_addr_age();
      wlog.delete();
      bus.req1_valid = 1'b1; bus.req1_addr = 4'd5; bus.req1_data = 32'h11;
      tick();
      drive_idle();
      bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 32'h22;
      tick();
      drive_idle();
      n_tests++;
      if ({bus.rf_enable, bus.rf_pc} !== {1'b1, 32'h11}) begin
         n_fail++; $display("FAIL age_first: got en %b pc %h expected 1 00000011", bus.rf_enable, bus.rf_pc);
      end
      tick();
      n_tests++;
      if ({bus.rf_enable, bus.rf_pc} !== {1'b1, 32'h22}) begin
         n_fail++; $display("FAIL age_second: got en %b pc %h expected 1 00000022", bus.rf_enable, bus.rf_pc);
      end
      tick();
      n_tests++;
      if (wlog.size() != 2 || tb_rf[5] !== 32'h22) begin
         n_fail++; $display("FAIL age_final: got writes %0d rf5 %h expected 2 00000022", wlog.size(), tb_rf[5]);
      end
      $display("[TB] same-address age writes=%0d rf5=%h", wlog.size(), tb_rf[5]);
   endtask

   task automatic test_simul_same_addr();
      wlog.delete();
      bus.req0_valid = 1'b1; bus.req0_addr = 4'd7; bus.req0_data = 32'hA;
      bus.req1_valid = 1'b1; bus.req1_addr = 4'd7; bus.req1_data = 32'hB;
      tick();
      drive_idle();
      tick();
      n_tests++;
      if ({bus.rf_enable, bus.rf_c, bus.rf_pc} !== {1'b1, 4'd7, 32'hA}) begin
         n_fail++; $display("FAIL simul_first: got en %b c %0d pc %h expected 1 7 0000000a", bus.rf_enable, bus.rf_c, bus.rf_pc);
      end
      tick();
      n_tests++;
      if ({bus.rf_enable, bus.rf_c, bus.rf_pc} !== {1'b1, 4'd7, 32'hB}) begin
         n_fail++; $display("FAIL simul_second: got en %b c %0d pc %h expected 1 7 0000000b", bus.rf_enable, bus.rf_c, bus.rf_pc);
      end
      tick();
      n_tests++;
      if (tb_rf[7] !== 32'hB || bus.pending_mask !== 16'h0) begin
         n_fail++; $display("FAIL simul_final: got rf7 %h mask %h expected 0000000b 0000", tb_rf[7], bus.pending_mask);
      end
      $display("[TB] simultaneous same-address rf7=%h", tb_rf[7]);
   endtask

   task automatic test_random();
      logic [56:0] got, exp;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bus.req0_valid = ($urandom_range(0, 3) != 0);
         bus.req0_addr  = 4'($urandom_range(0, 3));
         bus.req0_data  = $urandom;
         bus.req1_valid = ($urandom_range(0, 3) != 0);
         bus.req1_addr  = 4'($urandom_range(0, 3));
         bus.req1_data  = $urandom;
`ifdef REGFILE_ARB_BYPASS_EN
         bus.rd_a = 4'($urandom_range(0, 4));
         bus.rd_b = 4'($urandom_range(0, 4));
`endif
         tick();
         got = {bus.rf_enable, bus.rf_c, bus.rf_pc, bus.pending_mask, bus.busy, bus.req0_ready, bus.req1_ready, 1'b0};
         exp = {m_en, m_c, m_pc, model_mask(), m_v[0] | m_v[1] | m_en, !m_v[0], !m_v[1], 1'b0};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL random_cycle %0d: got %h expected %h", i, got, exp);
         end
`ifdef REGFILE_ARB_BYPASS_EN
         begin
            logic ha, hb;
            logic [31:0] da, db;
            model_fwd(bus.rd_a, ha, da);
            model_fwd(bus.rd_b, hb, db);
            n_tests++;
            if (bus.fwd_a_hit !== ha || bus.fwd_b_hit !== hb ||
                (ha && bus.fwd_a_data !== da) || (hb && bus.fwd_b_data !== db)) begin
               n_fail++; $display("FAIL random_fwd %0d: got %b %h %b %h expected %b %h %b %h", i,
                                  bus.fwd_a_hit, bus.fwd_a_data, bus.fwd_b_hit, bus.fwd_b_data, ha, da, hb, db);
            end
         end
`endif
      end
      drive_idle();
      tick(); tick(); tick();
      $display("[TB] random run 400 cycles done");
   endtask

`ifdef REGFILE_ARB_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_addr = 4'd4; bus.req0_data = 32'h55;
      tick();
      drive_idle();
      bus.rd_a = 4'd4; bus.rd_b = 4'd6;
      #1;
      n_tests++;
      if ({bus.fwd_a_hit, bus.fwd_a_data, bus.fwd_b_hit} !== {1'b1, 32'h55, 1'b0}) begin
         n_fail++; $display("FAIL bypass: got a %b %h b %b expected 1 00000055 0", bus.fwd_a_hit, bus.fwd_a_data, bus.fwd_b_hit);
      end
      tick(); tick();
      $display("[TB] bypass hold0 addr 4 forwarded");
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_same_addr_age();
      test_simul_same_addr();
      test_random();
`ifdef REGFILE_ARB_BYPASS_EN
      test_bypass();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
